// File: rtl/cdc_sync_bus_filter_if.sv
// Level-signal bundle for the per-bit synchroniser/filter.
// master drives the async levels; slave is the synchroniser.
interface cdc_sync_bus_filter_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] async_in;
  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;
  logic             any_change;

  modport master (
    output async_in,
    input  sync_out,
    input  rise_pulse,
    input  fall_pulse,
    input  any_change
  );

  modport slave (
    input  async_in,
    output sync_out,
    output rise_pulse,
    output fall_pulse,
    output any_change
  );
endinterface

// File: rtl/cdc_sync_bus_filter.sv
// Per-bit level synchroniser with optional stability filter
// and rise/fall edge pulses in the destination clock domain.
module cdc_sync_bus_filter #(
  parameter int             WIDTH     = 8,
  parameter int             STAGES    = 2,
  parameter int             FILTER    = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic                  clk,
  input logic                  rst,
  cdc_sync_bus_filter_if.slave bus
);

  if (STAGES < 2) begin : g_bad_stages
    $error("cdc_sync_bus_filter: STAGES must be >= 2");
  end

  (* ASYNC_REG = "TRUE" *)
  logic [WIDTH-1:0] stage_q [STAGES];

  logic [WIDTH-1:0] tail_w;
  logic [WIDTH-1:0] out_w;
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= RESET_VAL;
      end
    end else begin
      stage_q[0] <= bus.async_in;
      for (int k = 1; k < STAGES; k++) begin
        stage_q[k] <= stage_q[k-1];
      end
    end
  end

  assign tail_w = stage_q[STAGES-1];

  if (FILTER == 0) begin : g_nofilt
    assign out_w = tail_w;
  end else begin : g_filt
    localparam int CW = $clog2(FILTER + 1);
    localparam logic [CW-1:0] CMAX = CW'(FILTER - 1);

    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;

    // Count consecutive mismatch cycles; follow on the FILTER-th.
    always_comb begin
      out_d = out_q;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_d[i] = '0;
        if (tail_w[i] != out_q[i]) begin
          if (cnt_q[i] == CMAX) begin
            out_d[i] = tail_w[i];
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        out_q <= RESET_VAL;
        for (int i = 0; i < WIDTH; i++) begin
          cnt_q[i] <= '0;
        end
      end else begin
        out_q <= out_d;
        for (int i = 0; i < WIDTH; i++) begin
          cnt_q[i] <= cnt_d[i];
        end
      end
    end

    assign out_w = out_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= RESET_VAL;
    end else begin
      prev_q <= out_w;
    end
  end

  assign bus.sync_out   = out_w;
  assign bus.rise_pulse = out_w & ~prev_q;
  assign bus.fall_pulse = ~out_w & prev_q;
  assign bus.any_change = |(out_w ^ prev_q);

endmodule

// File: tb/tb_cdc_sync_bus_filter.sv
// Directed and randomised checks for cdc_sync_bus_filter
// across unfiltered, filtered and non-zero-reset instances.
module tb_cdc_sync_bus_filter;

  logic clk;
  logic rst_a;
  logic rst_b;
  logic rst_c;

  int checks;
  int errors;

  cdc_sync_bus_filter_if #(.WIDTH(8)) ia ();
  cdc_sync_bus_filter_if #(.WIDTH(4)) ib ();
  cdc_sync_bus_filter_if #(.WIDTH(4)) ic ();

  cdc_sync_bus_filter #(
    .WIDTH(8), .STAGES(2), .FILTER(0)
  ) u_a (
    .clk(clk), .rst(rst_a), .bus(ia)
  );

  cdc_sync_bus_filter #(
    .WIDTH(4), .STAGES(3), .FILTER(4)
  ) u_b (
    .clk(clk), .rst(rst_b), .bus(ib)
  );

  cdc_sync_bus_filter #(
    .WIDTH(4), .STAGES(2), .FILTER(2),
    .RESET_VAL(4'hA)
  ) u_c (
    .clk(clk), .rst(rst_c), .bus(ic)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference for instance b (S=3, F=4, reset 0)
  logic [3:0] m_ch [3];
  logic [2:0] m_run [4];
  logic [3:0] m_out;
  logic [3:0] m_prev;

  task automatic mdl_tick();
    if (rst_b) begin
      for (int k = 0; k < 3; k++) m_ch[k] = '0;
      for (int i = 0; i < 4; i++) m_run[i] = '0;
      m_out  = '0;
      m_prev = '0;
    end else begin
      m_prev = m_out;
      for (int i = 0; i < 4; i++) begin
        if (m_ch[2][i] != m_out[i]) begin
          m_run[i] = m_run[i] + 3'd1;
          if (m_run[i] == 3'd4) begin
            m_out[i] = m_ch[2][i];
            m_run[i] = '0;
          end
        end else begin
          m_run[i] = '0;
        end
      end
      m_ch[2] = m_ch[1];
      m_ch[1] = m_ch[0];
      m_ch[0] = ib.async_in;
    end
  endtask

  task automatic step();
    @(posedge clk);
    mdl_tick();
    #1;
  endtask

  logic [3:0] last_up;
  logic [3:0] exp4;

  initial begin
    checks = 0;
    errors = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    rst_c = 1'b1;
    ia.async_in = 8'h00;
    ib.async_in = 4'h0;
    ic.async_in = 4'hA;
    step();
    step();

    chk("rst_a_sync", ia.sync_out, 8'h00);
    chk("rst_a_any", ia.any_change, 1'b0);
    chk("rst_b_sync", ib.sync_out, 4'h0);
    chk("rst_c_sync", ic.sync_out, 4'hA);
    chk("rst_c_edge", ic.rise_pulse | ic.fall_pulse, 4'h0);

    // 1: single bit through S=2 unfiltered
    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;
    ia.async_in = 8'h01;
    step();
    chk("t1_e1_sync", ia.sync_out, 8'h00);
    step();
    chk("t1_e2_sync", ia.sync_out, 8'h01);
    chk("t1_e2_rise", ia.rise_pulse, 8'h01);
    chk("t1_e2_any", ia.any_change, 1'b1);
    step();
    chk("t1_e3_rise", ia.rise_pulse, 8'h00);
    chk("t1_e3_any", ia.any_change, 1'b0);

    // 5: simultaneous multi-bit changes
    ia.async_in = 8'h00;
    for (int n = 0; n < 4; n++) step();
    ia.async_in = 8'hF0;
    step();
    chk("t5_a_early", ia.rise_pulse, 8'h00);
    step();
    chk("t5_a_rise", ia.rise_pulse, 8'hF0);
    chk("t5_a_fall", ia.fall_pulse, 8'h00);
    step();
    step();
    ia.async_in = 8'h0F;
    step();
    step();
    chk("t5_b_sync", ia.sync_out, 8'h0F);
    chk("t5_b_rise", ia.rise_pulse, 8'h0F);
    chk("t5_b_fall", ia.fall_pulse, 8'hF0);
    chk("t5_b_any", ia.any_change, 1'b1);

    // 2: S=3,F=4 latency of 7 edges
    ib.async_in = 4'b0100;
    for (int n = 0; n < 6; n++) step();
    chk("t2_e6_sync", ib.sync_out, 4'h0);
    step();
    chk("t2_e7_sync", ib.sync_out, 4'h4);
    chk("t2_e7_rise", ib.rise_pulse, 4'h4);
    step();
    chk("t2_e8_rise", ib.rise_pulse, 4'h0);
    chk("t2_e8_any", ib.any_change, 1'b0);

    // 3a: 3-cycle glitch on bit0 is swallowed
    ib.async_in = 4'b0101;
    for (int e = 1; e <= 12; e++) begin
      step();
      if (e == 3) ib.async_in = 4'b0100;
      chk("t3_g3_sync", ib.sync_out, 4'h4);
      chk("t3_g3_any", ib.any_change, 1'b0);
    end

    // 3b: 4-cycle glitch on bit0 passes
    ib.async_in = 4'b0101;
    for (int e = 1; e <= 13; e++) begin
      step();
      if (e == 4) ib.async_in = 4'b0100;
      exp4 = (e >= 7 && e <= 10) ? 4'h5 : 4'h4;
      chk("t3_g4_sync", ib.sync_out, exp4);
      chk("t3_g4_rise", ib.rise_pulse,
          (e == 7) ? 4'h1 : 4'h0);
      chk("t3_g4_fall", ib.fall_pulse,
          (e == 11) ? 4'h1 : 4'h0);
    end

    // 4: reset aborts a pending count, RESET_VAL=A
    ic.async_in = 4'h8;
    step();
    step();
    step();
    chk("t4_pend_sync", ic.sync_out, 4'hA);
    rst_c = 1'b1;
    step();
    chk("t4_rst_sync", ic.sync_out, 4'hA);
    chk("t4_rst_any", ic.any_change, 1'b0);
    rst_c = 1'b0;
    ic.async_in = 4'hA;
    for (int n = 0; n < 8; n++) begin
      step();
      chk("t4_hold_sync", ic.sync_out, 4'hA);
      chk("t4_hold_any", ic.any_change, 1'b0);
    end

    // 6: random levels and resets against the model
    rst_b = 1'b1;
    step();
    step();
    rst_b = 1'b0;
    last_up = 4'h0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        ib.async_in = 4'($urandom);
      end
      rst_b = ($urandom_range(0, 59) == 0);
      step();
      chk("t6_sync", ib.sync_out, m_out);
      chk("t6_rise", ib.rise_pulse, m_out & ~m_prev);
      chk("t6_fall", ib.fall_pulse, ~m_out & m_prev);
      chk("t6_any", ib.any_change, |(m_out ^ m_prev));
      if (rst_b) last_up = 4'h0;
      for (int i = 0; i < 4; i++) begin
        if (ib.rise_pulse[i]) begin
          chk("t6_alt_rise", last_up[i], 1'b0);
          last_up[i] = 1'b1;
        end
        if (ib.fall_pulse[i]) begin
          chk("t6_alt_fall", last_up[i], 1'b1);
          last_up[i] = 1'b0;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
